info_packer: RTL and testbench
==============================

Name: info_packer

Overview:
- Upstream feeder for the counter stage. Accepts a single-address request stream over a valid/ready handshake and buffers it in a small FIFO.
- Each enabled cycle it emits one info_t beat carrying up to two addresses in lanes 0 and 1.
- It waits a bounded time to pair a lone entry before issuing it single, so the counter sees dense two-lane beats.

Parameters:
- DEPTH, 8, FIFO entries; power of two, at least 2.
- TMO, 3, max cycles a lone entry waits for a partner; 0 means issue singles immediately.
- ADDR_W, 8, address width; from the package, must match the info_t addr width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  issue enable; drives the counter's flag_cnt domain.
- flush  in  1  force issue of a lone waiting entry without waiting for TMO.
- in_vld  in  1  request valid.
- in_addr  in  ADDR_W  request address.
- in_rdy  out  1  FIFO can accept.
- info_o  out  info_t  vld[1:0] and addr[1:0] beat to the counter.
- fill_o  out  $clog2(DEPTH+1)  registered occupancy.

Behaviour:
- Reset (rst=0, async):
  - pointers, count, timer and info_o go to all-zero; FSM goes to IDLE.
  - in_rdy forced 0 while rst is low.
  - Any buffered contents are discarded, including mid-wait.
- Push:
  - Fires on in_vld && in_rdy.
  - in_rdy = (count != DEPTH); it does not depend on same-cycle pop (no bypass).
- Occupancy:
  - count_next = count + push − pops, with pops ∈ {0,1,2}. Simultaneous push and pop are legal.
  - Count never exceeds DEPTH or goes below 0.
  - fill_o = count.
- Issue decision:
  - Based on the registered count; info_o is registered.
  - An entry accepted at edge E0 appears on info_o at edge E1 at the earliest.
- en=1, count>=2:
  - Pop 2: info_o.vld=2'b11, addr[0]=oldest entry, addr[1]=next oldest.
  - FSM goes to IDLE and the timer clears.
- en=1, count==1:
  - IDLE:
    - TMO==0 or flush: issue single (vld=2'b01, addr[0]=entry).
    - Otherwise: go to WAIT, timer=0, vld=0.
  - WAIT:
    - Timer increments each en cycle.
    - When timer==TMO-1 or flush is high, issue single and return to IDLE.
    - If count reaches 2 first, the pair rule applies.
- en=1, count==0: vld=0; FSM returns to IDLE.
- en=0:
  - No pops; info_o.vld=0; FSM and timer frozen.
  - Pushes continue.
- Lane rules:
  - vld=2'b10 is never produced.
  - Lane order preserves FIFO order across beats.
  - addr[] holds its last value when the corresponding vld bit is 0. Checkers compare addr only under vld.
- Pointers wrap modulo DEPTH. Full and empty are distinguished via count, not pointer equality.
- Data integrity: every accepted address is issued exactly once, in order, unless reset intervenes.

Decomposition:
- template_pkg (shared):
  - existing info_t and CNT_WIDTH.
  - add ADDR_W=8, NUM_LANE=2.
  - add packer_state_e {IDLE, WAIT}.
- Sub-module info_fifo:
  - Parameterised DEPTH × ADDR_W storage.
  - One write port and two-entry head peek (head, head+1).
  - Pop-count input 0..2 and count output.
  - Same clk and async active-low rst.
- info_packer holds the FSM, timer, issue logic and output register.

Test Plan:
1. Reset: hold rst=0 with in_vld=1 → info_o=0, in_rdy=0, fill_o=0. Release rst → in_rdy=1 next cycle; nothing was captured during reset.
2. Pair: en=1, push 0x11 then 0x22 on consecutive cycles → one beat with vld=11, addr0=0x11, addr1=0x22; no single beat for 0x11, provided 0x22 arrives within TMO.
3. Timeout, TMO=3, two cases:
   - Push 0x33 alone → vld=01, addr0=0x33 on the 3rd cycle after it becomes visible.
   - Push 0x33, then 0x44 one cycle later → paired beat 0x33/0x44.
4. Full/backpressure: en=0, push 0x01..0x08 → in_rdy=0, fill_o=8; 9th push (0x09) not accepted. Then en=1 → 4 beats (01/02, 03/04, 05/06, 07/08); in_rdy=1 again the cycle after the first pop.
5. Flush: one entry 0x5A in WAIT, flush=1 → single beat vld=01, addr0=0x5A at the next edge, before the timeout.
6. Reset mid-operation: 3 entries buffered, FSM in WAIT, assert rst asynchronously between edges → info_o.vld=0 and fill_o=0 immediately. After release, the bench pushes 0x77,0x78 → pair beat 0x77/0x78; no stale data emitted.

Source files
------------

// File: rtl/info_packer_pkg.sv
// Shared types and constants for the info packer and the counter stage it feeds.
//   info_t         : one beat of up to NUM_LANE addresses, each lane qualified by vld
//   packer_state_e : packer FSM states (IDLE, WAIT for a pairing partner)
package info_packer_pkg;

   localparam int CNT_WIDTH = 4;
   localparam int ADDR_W    = 8;
   localparam int NUM_LANE  = 2;

   typedef struct packed {
      logic [NUM_LANE-1:0]             vld;
      logic [NUM_LANE-1:0][ADDR_W-1:0] addr;
   } info_t;

   typedef enum logic {
      IDLE = 1'b0,
      WAIT = 1'b1
   } packer_state_e;

endpackage

// File: rtl/info_packer_if.sv
// Request/issue bus of the info packer.
//   en, flush       : issue enable and force-issue of a lone waiting entry
//   in_vld/in_addr  : request stream, accepted when in_rdy is high
//   info_o          : registered two-lane beat towards the counter
//   fill_o          : registered FIFO occupancy
// master = request source / beat consumer, slave = the packer itself.
interface info_packer_if #(
   parameter int DEPTH = 8
) ();
   import info_packer_pkg::*;

   localparam int FILL_W = $clog2(DEPTH + 1);

   logic              en;
   logic              flush;
   logic              in_vld;
   logic [ADDR_W-1:0] in_addr;
   logic              in_rdy;
   info_t             info_o;
   logic [FILL_W-1:0] fill_o;

   modport master (
      output en, flush, in_vld, in_addr,
      input  in_rdy, info_o, fill_o
   );

   modport slave (
      input  en, flush, in_vld, in_addr,
      output in_rdy, info_o, fill_o
   );

endinterface

// File: rtl/info_packer_fifo.sv
// Address FIFO of the info packer: one write port, a two-entry head peek
// (head0 = oldest, head1 = next oldest) and a pop of 0..2 entries per cycle.
//   clk, rst            : clock and asynchronous active-low reset
//   push, push_addr     : write one entry (caller guarantees not full)
//   pop_cnt             : entries to remove this cycle (caller guarantees <= count)
//   head0, head1, count : peek data and registered occupancy
module info_fifo
   import info_packer_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic [ADDR_W-1:0] push_addr,
   input  logic [1:0]        pop_cnt,
   output logic [ADDR_W-1:0] head0,
   output logic [ADDR_W-1:0] head1,
   output logic [CNT_W-1:0]  count
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [ADDR_W-1:0] mem_q [DEPTH];
   logic [ADDR_W-1:0] mem_d [DEPTH];

   // Pointers wrap naturally because DEPTH is a power of two; full/empty
   // are told apart by count, never by pointer equality.
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      if (push) begin
         mem_d[wr_ptr_q] = push_addr;
         wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      rd_ptr_d = rd_ptr_q + PTR_W'(pop_cnt);
      count_d  = count_q + CNT_W'(push) - CNT_W'(pop_cnt);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: only entries below count are ever observed.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign head0 = mem_q[rd_ptr_q];
   assign head1 = mem_q[rd_ptr_q + PTR_W'(1)];
   assign count = count_q;

endmodule

// File: rtl/info_packer.sv
// Info packer: buffers single-address requests and issues them as dense
// two-lane beats, waiting up to TMO enabled cycles to pair a lone entry.
//   clk, rst : clock and asynchronous active-low reset
//   bus      : info_packer_if slave (en, flush, in_vld/in_addr/in_rdy, info_o, fill_o)
module info_packer
   import info_packer_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int TMO   = 3
) (
   input  logic         clk,
   input  logic         rst,
   info_packer_if.slave bus
);

   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int TMR_W = (TMO > 1) ? $clog2(TMO) : 1;
   localparam logic [TMR_W-1:0] TMR_LAST = (TMO > 0) ? TMR_W'(TMO - 1) : '0;

   packer_state_e     state_q, state_d;
   logic [TMR_W-1:0]  timer_q, timer_d;
   info_t             info_q, info_d;
   logic [1:0]        pop_cnt;
   logic [ADDR_W-1:0] head0, head1;
   logic [CNT_W-1:0]  count;
   logic              push;
   logic              single_go;

   // in_rdy looks only at the registered count, so a pop in the same cycle
   // does not free a slot early; it is held low throughout reset.
   assign bus.in_rdy = rst && (count != CNT_W'(DEPTH));
   assign push       = bus.in_vld && bus.in_rdy;

   info_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_addr (bus.in_addr),
      .pop_cnt   (pop_cnt),
      .head0     (head0),
      .head1     (head1),
      .count     (count)
   );

   // A lone entry goes out single when waiting is disabled, when flushed,
   // or when it has already spent TMO enabled cycles in WAIT.
   always_comb begin
      if (state_q == IDLE) single_go = (TMO == 0) || bus.flush;
      else                 single_go = (timer_q == TMR_LAST) || bus.flush;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= IDLE;
      else      state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (bus.en) begin
         if (count >= CNT_W'(2))      state_d = IDLE;
         else if (count == CNT_W'(1)) state_d = single_go ? IDLE : WAIT;
         else                         state_d = IDLE;
      end
   end

   // Issue logic: lane 0 always carries the oldest entry, so vld=2'b10 is
   // impossible; addr keeps its previous value in unused lanes.
   always_comb begin
      info_d     = info_q;
      info_d.vld = '0;
      pop_cnt    = 2'd0;
      timer_d    = timer_q;
      if (bus.en) begin
         if (count >= CNT_W'(2)) begin
            pop_cnt        = 2'd2;
            info_d.vld     = 2'b11;
            info_d.addr[0] = head0;
            info_d.addr[1] = head1;
            timer_d        = '0;
         end else if (count == CNT_W'(1)) begin
            if (single_go) begin
               pop_cnt        = 2'd1;
               info_d.vld     = 2'b01;
               info_d.addr[0] = head0;
               timer_d        = '0;
            end else if (state_q == IDLE) begin
               timer_d = '0;
            end else begin
               timer_d = timer_q + TMR_W'(1);
            end
         end else begin
            timer_d = '0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         timer_q <= '0;
         info_q  <= '0;
      end else begin
         timer_q <= timer_d;
         info_q  <= info_d;
      end
   end

   assign bus.info_o = info_q;
   assign bus.fill_o = count;

endmodule

// File: tb/tb_info_packer.sv
// Self-checking bench for info_packer (DEPTH=8, TMO=3): a cycle table checks
// in_rdy/fill_o/beat timing while a scoreboard checks beat contents and order.
module tb_info_packer;
   import info_packer_pkg::*;

   localparam int DEPTH = 8;
   localparam int TMO   = 3;

   logic clk = 1'b0;
   logic rst = 1'b1;

   info_packer_if #(.DEPTH(DEPTH)) bus ();

   info_packer #(.DEPTH(DEPTH), .TMO(TMO)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       en;
      logic       flush;
      logic       in_vld;
      logic [7:0] in_addr;
      logic       exp_rdy;
      int         exp_fill;
      logic [1:0] exp_vld;
      logic [7:0] exp_a0;
      logic [7:0] exp_a1;
   } vec_t;

   typedef struct {
      logic [1:0] vld;
      logic [7:0] a0;
      logic [7:0] a1;
   } beat_t;

   beat_t sb_q[$];
   beat_t mon_exp;
   vec_t  vecs[$];
   int    checks = 0;
   int    errors = 0;

   function automatic vec_t mk(logic en, logic flush, logic vld, logic [7:0] addr,
                               logic rdy, int fill, logic [1:0] ov,
                               logic [7:0] a0, logic [7:0] a1);
      vec_t v;
      v.en = en; v.flush = flush; v.in_vld = vld; v.in_addr = addr;
      v.exp_rdy = rdy; v.exp_fill = fill; v.exp_vld = ov;
      v.exp_a0 = a0; v.exp_a1 = a1;
      return v;
   endfunction

   task automatic check_val(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Every beat leaving the DUT is matched in order against the scoreboard.
   always @(negedge clk) begin
      if (rst && bus.info_o.vld != 2'b00) begin
         if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_beat: got vld=%b addr0=0x%0h, expected no beat",
                     bus.info_o.vld, bus.info_o.addr[0]);
         end else begin
            mon_exp = sb_q.pop_front();
            check_val("beat_vld", int'(bus.info_o.vld), int'(mon_exp.vld));
            if (mon_exp.vld[0]) check_val("beat_addr0", int'(bus.info_o.addr[0]), int'(mon_exp.a0));
            if (mon_exp.vld[1]) check_val("beat_addr1", int'(bus.info_o.addr[1]), int'(mon_exp.a1));
         end
      end
   end

   task automatic apply_stimulus(input vec_t v);
      beat_t b;
      bus.en      = v.en;
      bus.flush   = v.flush;
      bus.in_vld  = v.in_vld;
      bus.in_addr = v.in_addr;
      if (v.exp_vld != 2'b00) begin
         b.vld = v.exp_vld;
         b.a0  = v.exp_a0;
         b.a1  = v.exp_a1;
         sb_q.push_back(b);
      end
   endtask

   task automatic check_output(input vec_t v);
      check_val("in_rdy", int'(bus.in_rdy), int'(v.exp_rdy));
      check_val("fill_o", int'(bus.fill_o), v.exp_fill);
      check_val("info_vld", int'(bus.info_o.vld), int'(v.exp_vld));
   endtask

   task automatic run_vec(input vec_t v);
      apply_stimulus(v);
      @(posedge clk);
      #1;
      check_output(v);
   endtask

   task automatic drain();
      for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(posedge clk);
      #1;
      check_val("scoreboard_drained", sb_q.size(), 0);
   endtask

   initial begin
      bus.en      = 1'b1;
      bus.flush   = 1'b0;
      bus.in_vld  = 1'b1;
      bus.in_addr = 8'hAA;

      // Reset held with a request pending: nothing may be captured.
      #2 rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_val("reset_info_o", int'(bus.info_o), 0);
      check_val("reset_in_rdy", int'(bus.in_rdy), 0);
      check_val("reset_fill", int'(bus.fill_o), 0);
      rst        = 1'b1;
      bus.in_vld = 1'b0;
      @(posedge clk);
      #1;
      check_val("post_reset_in_rdy", int'(bus.in_rdy), 1);
      check_val("post_reset_fill", int'(bus.fill_o), 0);

      // Pair, timeout single, late pair, flush in WAIT/IDLE, en freeze, odd count.
      vecs.push_back(mk(1,0,1,8'h11,1,1,2'b00,8'h00,8'h00));
      vecs.push_back(mk(1,0,1,8'h22,1,2,2'b00,8'h00,8'h00));
      vecs.push_back(mk(1,0,0,8'h00,1,0,2'b11,8'h11,8'h22));
      vecs.push_back(mk(1,0,0,8'h00,1,0,2'b00,8'h00,8'h00));
      vecs.push_back(mk(1,0,1,8'h33,1,1,2'b00,8'h00,8'h00));
      vecs.push_back(mk(1,0,0,8'h00,1,1,2'b00,8'h00,8'h00));
      vecs.push_back(mk(1,0,0,8'h00,1,1,2'b00,8'h00,8'h00));
      vecs.push_back(mk(1,0,0,8'h00,1,1,2'b00,8'h00,8'h00));
      vecs.push_back(mk(1,0,0,8'h00,1,0,2'b01,8'h33,8'h00));
      vecs.push_back(mk(1,0,0,8'h00,1,0,2'b00,8'h00,8'h00));
      vecs.push_back(mk(1,0,1,8'h33,1,1,2'b00,8'h00,8'h00));
      vecs.push_back(mk(1,0,1,8'h44,1,2,2'b00,8'h00,8'h00));
      vecs.push_back(mk(1,0,0,8'h00,1,0,2'b11,8'h33,8'h44));
      vecs.push_back(mk(1,0,0,8'h00,1,0,2'b00,8'h00,8'h00));
      vecs.push_back(mk(1,0,1,8'h5A,1,1,2'b00,8'h00,8'h00));
      vecs.push_back(mk(1,0,0,8'h00,1,1,2'b00,8'h00,8'h00));
      vecs.push_back(mk(1,1,0,8'h00,1,0,2'b01,8'h5A,8'h00));
      vecs.push_back(mk(1,0,0,8'h00,1,0,2'b00,8'h00,8'h00));
      vecs.push_back(mk(1,0,1,8'h5B,1,1,2'b00,8'h00,8'h00));
      vecs.push_back(mk(1,1,0,8'h00,1,0,2'b01,8'h5B,8'h00));
      vecs.push_back(mk(1,0,0,8'h00,1,0,2'b00,8'h00,8'h00));
      vecs.push_back(mk(0,0,1,8'h66,1,1,2'b00,8'h00,8'h00));
      vecs.push_back(mk(0,0,0,8'h00,1,1,2'b00,8'h00,8'h00));
      vecs.push_back(mk(0,0,1,8'h67,1,2,2'b00,8'h00,8'h00));
      vecs.push_back(mk(1,0,0,8'h00,1,0,2'b11,8'h66,8'h67));
      vecs.push_back(mk(1,0,1,8'h68,1,1,2'b00,8'h00,8'h00));
      vecs.push_back(mk(1,0,0,8'h00,1,1,2'b00,8'h00,8'h00));
      vecs.push_back(mk(0,0,0,8'h00,1,1,2'b00,8'h00,8'h00));
      vecs.push_back(mk(0,0,0,8'h00,1,1,2'b00,8'h00,8'h00));
      vecs.push_back(mk(1,0,0,8'h00,1,1,2'b00,8'h00,8'h00));
      vecs.push_back(mk(1,0,0,8'h00,1,1,2'b00,8'h00,8'h00));
      vecs.push_back(mk(1,0,0,8'h00,1,0,2'b01,8'h68,8'h00));
      vecs.push_back(mk(1,0,1,8'h80,1,1,2'b00,8'h00,8'h00));
      vecs.push_back(mk(1,0,1,8'h81,1,2,2'b00,8'h00,8'h00));
      vecs.push_back(mk(1,0,1,8'h82,1,1,2'b11,8'h80,8'h81));
      vecs.push_back(mk(1,0,0,8'h00,1,1,2'b00,8'h00,8'h00));
      vecs.push_back(mk(1,0,0,8'h00,1,1,2'b00,8'h00,8'h00));
      vecs.push_back(mk(1,0,0,8'h00,1,1,2'b00,8'h00,8'h00));
      vecs.push_back(mk(1,0,0,8'h00,1,0,2'b01,8'h82,8'h00));
      vecs.push_back(mk(1,0,0,8'h00,1,0,2'b00,8'h00,8'h00));

      foreach (vecs[i]) run_vec(vecs[i]);
      drain();

      // Fill to DEPTH with issue disabled; the extra push must bounce.
      for (int i = 1; i <= DEPTH; i++)
         run_vec(mk(0,0,1,8'(i),(i != DEPTH),i,2'b00,8'h00,8'h00));
      run_vec(mk(0,0,1,8'h09,0,DEPTH,2'b00,8'h00,8'h00));
      for (int k = 0; k < DEPTH / 2; k++)
         run_vec(mk(1,0,0,8'h00,1,DEPTH-2*(k+1),2'b11,8'(2*k+1),8'(2*k+2)));
      run_vec(mk(1,0,0,8'h00,1,0,2'b00,8'h00,8'h00));
      drain();

      // Asynchronous reset with three entries buffered and the FSM in WAIT.
      run_vec(mk(1,0,1,8'hC1,1,1,2'b00,8'h00,8'h00));
      run_vec(mk(1,0,0,8'h00,1,1,2'b00,8'h00,8'h00));
      run_vec(mk(0,0,1,8'hC2,1,2,2'b00,8'h00,8'h00));
      run_vec(mk(0,0,1,8'hC3,1,3,2'b00,8'h00,8'h00));
      bus.in_vld = 1'b0;
      #3 rst = 1'b0;
      #1;
      check_val("midreset_vld", int'(bus.info_o.vld), 0);
      check_val("midreset_fill", int'(bus.fill_o), 0);
      check_val("midreset_in_rdy", int'(bus.in_rdy), 0);
      @(posedge clk);
      #1 rst = 1'b1;
      run_vec(mk(1,0,1,8'h77,1,1,2'b00,8'h00,8'h00));
      run_vec(mk(1,0,1,8'h78,1,2,2'b00,8'h00,8'h00));
      run_vec(mk(1,0,0,8'h00,1,0,2'b11,8'h77,8'h78));
      run_vec(mk(1,0,0,8'h00,1,0,2'b00,8'h00,8'h00));
      run_vec(mk(1,0,0,8'h00,1,0,2'b00,8'h00,8'h00));
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
